// File: rtl/midi_parser_rs_pkg.sv
// Shared constants and types for the running-status MIDI parser.
package midi_parser_rs_pkg;

  localparam int MIDI_DATA_BITS = 7;

  localparam logic [3:0] CMD_NOTE_OFF = 4'h8;
  localparam logic [3:0] CMD_NOTE_ON  = 4'h9;
  localparam logic [3:0] CMD_POLY_AT  = 4'hA;
  localparam logic [3:0] CMD_CC       = 4'hB;
  localparam logic [3:0] CMD_PROG     = 4'hC;
  localparam logic [3:0] CMD_CH_AT    = 4'hD;
  localparam logic [3:0] CMD_PB       = 4'hE;

  localparam logic [7:0]  RT_THRESHOLD = 8'hF8;
  localparam logic [13:0] PB_CENTRE    = 14'h2000;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA1, ST_DATA2} state_e;

  // Number of data bytes that follow a channel status nibble.
  function automatic logic [1:0] data_len(input logic [3:0] cmd);
    return (cmd == CMD_PROG || cmd == CMD_CH_AT) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_status_decode.sv
// Combinational classification of one raw MIDI byte.
module midi_status_decode
  import midi_parser_rs_pkg::*;
(
  input  logic [7:0] midiByte_i,
  output logic       isRealtime_o,
  output logic       isSysCommon_o,
  output logic       isChannelStatus_o,
  output logic       isData_o,
  output logic [1:0] dataLen_o
);

  assign isRealtime_o      = (midiByte_i >= RT_THRESHOLD);
  assign isSysCommon_o     = (midiByte_i[7:4] == 4'hF) && !isRealtime_o;
  assign isChannelStatus_o = midiByte_i[7] && (midiByte_i[7:4] != 4'hF);
  assign isData_o          = !midiByte_i[7];
  assign dataLen_o         = data_len(midiByte_i[7:4]);

endmodule

// File: rtl/midi_parser_rs.sv
// MIDI byte-stream parser with running status, real-time interleaving and
// channel/omni filtering; emits registered one-cycle event strobes.
module midi_parser_rs
  import midi_parser_rs_pkg::*;
#(
  parameter int MIDI_CHANNEL = 0,
  parameter int OMNI         = 0,
  parameter int VEL0_IS_OFF  = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      midiByteValid_i,
  input  logic [7:0]                midiByte_i,
  output logic [MIDI_DATA_BITS-1:0] note_o,
  output logic [MIDI_DATA_BITS-1:0] velocity_o,
  output logic [3:0]                channel_o,
  output logic [MIDI_DATA_BITS-1:0] ccNum_o,
  output logic [MIDI_DATA_BITS-1:0] ccVal_o,
  output logic [13:0]               pitchBend_o,
  output logic                      noteOnStrb_o,
  output logic                      noteOffStrb_o,
  output logic                      ccStrb_o,
  output logic                      pbStrb_o
);

  logic       isRealtime, isSysCommon, isChannelStatus, isData;
  logic [1:0] dataLen;

  midi_status_decode u_decode (
    .midiByte_i        (midiByte_i),
    .isRealtime_o      (isRealtime),
    .isSysCommon_o     (isSysCommon),
    .isChannelStatus_o (isChannelStatus),
    .isData_o          (isData),
    .dataLen_o         (dataLen)
  );

  state_e                    state_q;
  logic                      rsValid_q;
  logic [3:0]                cmd_q;
  logic [3:0]                chan_q;
  logic                      len2_q;
  logic [MIDI_DATA_BITS-1:0] d1_q;

  logic                      firstByte_d, accept_d, done_d, match_d;
  logic [MIDI_DATA_BITS-1:0] d1_d, d2_d;

  // In IDLE with running status the byte is treated exactly as data1.
  always_comb begin
    firstByte_d = (state_q != ST_DATA2);
    accept_d    = midiByteValid_i && isData && (state_q != ST_IDLE || rsValid_q);
    done_d      = accept_d && (!firstByte_d || !len2_q);
    d1_d        = firstByte_d ? midiByte_i[MIDI_DATA_BITS-1:0] : d1_q;
    d2_d        = firstByte_d ? '0 : midiByte_i[MIDI_DATA_BITS-1:0];
    match_d     = (OMNI != 0) || (chan_q == 4'(MIDI_CHANNEL));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rsValid_q     <= 1'b0;
      cmd_q         <= '0;
      chan_q        <= '0;
      len2_q        <= 1'b0;
      d1_q          <= '0;
      note_o        <= '0;
      velocity_o    <= '0;
      channel_o     <= '0;
      ccNum_o       <= '0;
      ccVal_o       <= '0;
      pitchBend_o   <= PB_CENTRE;
      noteOnStrb_o  <= 1'b0;
      noteOffStrb_o <= 1'b0;
      ccStrb_o      <= 1'b0;
      pbStrb_o      <= 1'b0;
    end else begin
      noteOnStrb_o  <= 1'b0;
      noteOffStrb_o <= 1'b0;
      ccStrb_o      <= 1'b0;
      pbStrb_o      <= 1'b0;

      // Real-time bytes fall through every branch and leave state untouched.
      if (midiByteValid_i) begin
        if (isSysCommon) begin
          rsValid_q <= 1'b0;
          state_q   <= ST_IDLE;
        end else if (isChannelStatus) begin
          cmd_q     <= midiByte_i[7:4];
          chan_q    <= midiByte_i[3:0];
          len2_q    <= (dataLen == 2'd2);
          rsValid_q <= 1'b1;
          state_q   <= ST_DATA1;
        end else if (accept_d) begin
          if (firstByte_d) d1_q <= midiByte_i[MIDI_DATA_BITS-1:0];
          state_q <= done_d ? ST_IDLE : ST_DATA2;
        end
      end

      if (done_d && match_d) begin
        unique case (cmd_q)
          CMD_NOTE_ON, CMD_NOTE_OFF: begin
            if (cmd_q == CMD_NOTE_ON && (d2_d != '0 || VEL0_IS_OFF == 0))
              noteOnStrb_o <= 1'b1;
            else
              noteOffStrb_o <= 1'b1;
            note_o     <= d1_d;
            velocity_o <= d2_d;
            channel_o  <= chan_q;
          end
          CMD_CC: begin
            ccStrb_o  <= 1'b1;
            ccNum_o   <= d1_d;
            ccVal_o   <= d2_d;
            channel_o <= chan_q;
          end
          CMD_PB: begin
            pbStrb_o    <= 1'b1;
            pitchBend_o <= {d2_d, d1_d};
            channel_o   <= chan_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/midi_parser_rs.md
Name: midi_parser_rs

Overview:
Parametrised successor to the single-channel note parser. It consumes the raw MIDI byte stream from the UART receiver and supports running status, real-time byte interleaving, a selectable channel or omni mode, and velocity output. It decodes Note On, Note Off, Control Change and Pitch Bend into registered single-cycle strobes with payloads, and sits between the UART RX and the voice/oscillator control logic.

Parameters:
MIDI_CHANNEL, 0, channel (0-15) accepted when OMNI=0.
OMNI, 0, 1 = accept all channels and report the source channel on channel_o.
VEL0_IS_OFF, 1, 1 = Note On with velocity 0 is reported as Note Off.

Ports:
clk_i  in  1  system clock; all logic on rising edge.
rst_i  in  1  synchronous reset, active-high.
midiByteValid_i  in  1  one-cycle qualifier for midiByte_i.
midiByte_i  in  8  received MIDI byte.
note_o  out  7  note number of the last note event.
velocity_o  out  7  velocity of the last note event.
channel_o  out  4  channel of the last reported event.
ccNum_o  out  7  controller number of the last CC.
ccVal_o  out  7  controller value of the last CC.
pitchBend_o  out  14  last pitch bend, {MSB,LSB}; 0x2000 = centre.
noteOnStrb_o  out  1  one-cycle Note On event.
noteOffStrb_o  out  1  one-cycle Note Off event.
ccStrb_o  out  1  one-cycle CC event.
pbStrb_o  out  1  one-cycle pitch bend event.

Behaviour:
- Reset (rst_i=1 at a clock edge): clock and reset are as already decided; reset is synchronous and active-high.
  - All strobes 0; note_o, velocity_o, channel_o, ccNum_o, ccVal_o = 0; pitchBend_o = 0x2000.
  - FSM goes to IDLE; running status is cleared (rsValid=0).
  - Reset mid-message discards the partial message.
- Only cycles with midiByteValid_i=1 are acted on; all other cycles hold state.
- Byte classes:
  - Real-time 0xF8-0xFF: ignored completely; FSM, running status and the partial message are untouched.
  - System common/exclusive 0xF0-0xF7: clear rsValid, go to IDLE, produce no event.
  - Channel status 0x80-0xEF: latch cmd[3:0] and channel[3:0], set rsValid=1, go to DATA1. This aborts any partial message silently.
  - Data byte 0x00-0x7F: handled per the FSM below.
- Data length: cmd 8,9,A,B,E take 2 data bytes; cmd C,D take 1.
- FSM states IDLE, DATA1, DATA2:
  - IDLE + data byte, rsValid=1: running status applies; the byte is treated as data1.
  - IDLE + data byte, rsValid=0: byte discarded.
  - DATA1 + data byte: store d1. For a 1-byte cmd the message completes and the FSM goes to IDLE; otherwise go to DATA2.
  - DATA2 + data byte: store d2; message completes; go to IDLE.
  - Running status stays valid after completion, so the next data byte starts a new message.
- Channel match: match = OMNI | (channel == MIDI_CHANNEL). Non-matching messages are parsed fully but produce no strobes and no payload updates.
- Completion of a matching message:
  - 0x9: if d2 != 0, or VEL0_IS_OFF=0, assert noteOnStrb_o; otherwise assert noteOffStrb_o.
  - 0x8: assert noteOffStrb_o.
  - Note events: note_o=d1, velocity_o=d2.
  - 0xB: ccStrb_o with ccNum_o=d1, ccVal_o=d2.
  - 0xE: pbStrb_o with pitchBend_o={d2,d1}.
  - 0xA, 0xC, 0xD: consumed silently.
  - channel_o is updated with every strobe.
- Latency and timing:
  - All outputs are registered.
  - A strobe is high for exactly the one cycle after the final data byte is accepted; payloads are valid in that same cycle and are held afterwards.
  - At most one strobe is high in any cycle.
  - Back-to-back valid bytes on consecutive cycles must be supported, including a completion followed immediately by a running-status data byte.

Decomposition:
- global.v gains:
  - `MIDI_DATA_BITS = 7
  - cmd nibble constants: NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CC=B, PROG=C, CH_AT=D, PB=E
  - real-time threshold 0xF8
  - pitch bend centre 0x2000
- One combinational sub-module, midi_status_decode, takes the byte and returns {isRealtime, isSysCommon, isChannelStatus, isData, dataLen}.
- The parser FSM and output registers stay in the top module.

Test Plan:
- Byte sequence 0x90,0x3C,0x64 -> one noteOnStrb_o pulse, 1 cycle after 0x64; note_o=0x3C, velocity_o=0x64, channel_o=0.
- Byte sequence 0x90,0x3C,0x64,0x40,0x50,0x3C,0x00 (running status, VEL0_IS_OFF=1) -> noteOn 0x3C, then noteOn 0x40 with velocity 0x50, then noteOff 0x3C with velocity 0.
- Byte sequence 0x90,0xF8,0x3C,0xFE,0x64 (real-time bytes interleaved) -> identical result to the first scenario.
- With MIDI_CHANNEL=0, OMNI=0, byte sequence 0x91,0x3C,0x64 -> no strobes, outputs unchanged. With OMNI=1, the same sequence -> noteOn and channel_o=1.
- Byte sequence 0xB0,0x07,0x7F, then 0xE0,0x00,0x40 -> ccStrb_o with ccNum_o=7, ccVal_o=0x7F; then pbStrb_o with pitchBend_o=0x2000.
- Byte sequence 0x90,0x3C,0xF0,0x40 -> no strobe and the 0x40 is discarded. Separately, rst_i asserted between 0x90 and 0x3C -> the partial message is dropped and outputs return to their reset values.
